// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: eight-digit multiplexed 7-segment scanner with blanking gaps and tear-free paging.
// Define DISP_LZB_EN to blank leading zero digits (digit 0 always shown).
module disp_scan_ctrl #(
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic        clk100MHz,
  input  logic        rst,
  input  logic        tick_scan_in,
  input  logic        tick_page_in,
  input  logic        auto_en,
  input  logic        page_sel,
  input  logic [31:0] page0,
  input  logic [31:0] page1,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        page,
  output logic        frame_done
);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  localparam logic [7:0] BLANK_LOAD = 8'(BLANK_CYC - 1);

  state_t      state_q, state_d;
  logic [7:0]  blank_cnt_q, blank_cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] snap_q, snap_d;
  logic        page_q, page_d;
  logic        pend_q, pend_d;
  logic [2:0]  scan_sync_q, scan_sync_d;
  logic [2:0]  page_sync_q, page_sync_d;
  logic        scan_p_q, scan_p_d;
  logic        page_p_q, page_p_d;
  logic [7:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic        frame_done_q, frame_done_d;

  logic        reload;
  logic [7:0]  blank_mask;
  logic        digit_off;
  logic        lit;
  logic [3:0]  nibble;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

`ifdef DISP_LZB_EN
  // Bit k set when nibbles 7..k of the word are all zero; bit 0 never set.
  function automatic logic [7:0] lead_zero_mask(input logic [31:0] word);
    logic       run;
    logic [7:0] mask;
    run  = 1'b1;
    mask = 8'h00;
    for (int j = 7; j >= 1; j--) begin
      run     = run & (word[4*j +: 4] == 4'h0);
      mask[j] = run;
    end
    return mask;
  endfunction
`endif

  always_comb begin
    scan_sync_d = {scan_sync_q[1:0], tick_scan_in};
    page_sync_d = {page_sync_q[1:0], tick_page_in};
    scan_p_d    = scan_sync_q[1] & ~scan_sync_q[2];
    page_p_d    = page_sync_q[1] & ~page_sync_q[2];

    // A page pulse landing on a reload cycle is folded in before the reload samples it.
    pend_d = auto_en ? (pend_q ^ page_p_q) : page_sel;

    state_d      = state_q;
    blank_cnt_d  = blank_cnt_q;
    idx_d        = idx_q;
    snap_d       = snap_q;
    page_d       = page_q;
    frame_done_d = 1'b0;
    reload       = 1'b0;

    case (state_q)
      IDLE: begin
        if (scan_p_q) begin
          state_d     = BLANK;
          blank_cnt_d = BLANK_LOAD;
          idx_d       = 3'd0;
          reload      = 1'b1;
        end
      end
      BLANK: begin
        if (blank_cnt_q == 8'd0) begin
          state_d = DRIVE;
        end else begin
          blank_cnt_d = blank_cnt_q - 8'd1;
        end
      end
      DRIVE: begin
        if (scan_p_q) begin
          state_d     = BLANK;
          blank_cnt_d = BLANK_LOAD;
          idx_d       = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            reload       = 1'b1;
            frame_done_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (reload) begin
      snap_d = pend_d ? page1 : page0;
      page_d = pend_d;
    end

`ifdef DISP_LZB_EN
    blank_mask = lead_zero_mask(snap_d);
`else
    blank_mask = 8'h00;
`endif
    digit_off = blank_mask[idx_d];
    lit       = (state_d == DRIVE) && !digit_off;
    nibble    = snap_d[{idx_d, 2'b00} +: 4];

    // Outputs are derived from next-state values so the pins change cleanly on the edge.
    an_d = lit ? ~(8'b0000_0001 << idx_d) : 8'hFF;
    seg_d = lit ? hex_decode(nibble) : 7'h7F;
    dp_d = ~((state_d == DRIVE) && (idx_d == 3'd0) && page_d);
  end

  always_ff @(posedge clk100MHz or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      blank_cnt_q  <= 8'd0;
      idx_q        <= 3'd0;
      snap_q       <= 32'd0;
      page_q       <= 1'b0;
      pend_q       <= 1'b0;
      scan_sync_q  <= 3'd0;
      page_sync_q  <= 3'd0;
      scan_p_q     <= 1'b0;
      page_p_q     <= 1'b0;
      an_q         <= 8'hFF;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      blank_cnt_q  <= blank_cnt_d;
      idx_q        <= idx_d;
      snap_q       <= snap_d;
      page_q       <= page_d;
      pend_q       <= pend_d;
      scan_sync_q  <= scan_sync_d;
      page_sync_q  <= page_sync_d;
      scan_p_q     <= scan_p_d;
      page_p_q     <= page_p_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign page       = page_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl: directed scenarios plus randomized ticks and pages,
// every cycle compared against a slot-level reference model of the scanner.
module tb_disp_scan_ctrl;

  localparam int BC       = 4;
  localparam int DARK     = 0;
  localparam int BLANKING = 1;
  localparam int SHOWING  = 2;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic        tickScan = 1'b0;
  logic        tickPage = 1'b0;
  logic        autoEn   = 1'b0;
  logic        pageSel  = 1'b0;
  logic [31:0] page0    = 32'h0;
  logic [31:0] page1    = 32'h0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        pageOut;
  logic        frameDone;

  always #5 clk = ~clk;

  disp_scan_ctrl #(.BLANK_CYC(BC)) dut (
    .clk100MHz   (clk),
    .rst         (rst),
    .tick_scan_in(tickScan),
    .tick_page_in(tickPage),
    .auto_en     (autoEn),
    .page_sel    (pageSel),
    .page0       (page0),
    .page1       (page1),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .page        (pageOut),
    .frame_done  (frameDone)
  );

  logic [6:0] hexTab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int errors = 0;
  int checks = 0;

  // Reference model: which slot is showing, which frame word is latched, which page is pending.
  int          mMode;
  int          mLeft;
  int          mDigit;
  logic [31:0] mFrame;
  bit          mShown;
  bit          mPend;
  bit          mDone;
  bit          scanHist[$];
  bit          pageHist[$];

  int         fdCount   = 0;
  logic [7:0] firstLit  = 8'hFF;
  bit         watchLit  = 1'b0;
  int         scanCnt   = 5;
  int         pageCnt   = 20;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic void modelReset();
    mMode  = DARK;
    mLeft  = 0;
    mDigit = 0;
    mFrame = 32'h0;
    mShown = 1'b0;
    mPend  = 1'b0;
    mDone  = 1'b0;
    scanHist.delete();
    pageHist.delete();
    repeat (5) begin
      scanHist.push_back(1'b0);
      pageHist.push_back(1'b0);
    end
  endfunction

  function automatic void modelReload();
    mFrame = mPend ? page1 : page0;
    mShown = mPend;
  endfunction

  // A rising edge sampled at clock t becomes visible to the scanner at clock t+3.
  function automatic void modelEdge();
    bit scanEvt;
    bit pageEvt;
    int n;
    if (rst == 1'b0) begin
      modelReset();
    end else begin
      scanHist.push_back(tickScan);
      pageHist.push_back(tickPage);
      if (scanHist.size() > 8) void'(scanHist.pop_front());
      if (pageHist.size() > 8) void'(pageHist.pop_front());
      n = scanHist.size();
      scanEvt = scanHist[n-4] && !scanHist[n-5];
      pageEvt = pageHist[n-4] && !pageHist[n-5];
      if (autoEn) mPend = mPend ^ pageEvt;
      else        mPend = pageSel;
      mDone = 1'b0;
      case (mMode)
        DARK: begin
          if (scanEvt) begin
            mMode  = BLANKING;
            mLeft  = BC;
            mDigit = 0;
            modelReload();
          end
        end
        BLANKING: begin
          mLeft--;
          if (mLeft == 0) mMode = SHOWING;
        end
        default: begin
          if (scanEvt) begin
            mMode = BLANKING;
            mLeft = BC;
            if (mDigit == 7) begin
              mDigit = 0;
              modelReload();
              mDone = 1'b1;
            end else begin
              mDigit++;
            end
          end
        end
      endcase
    end
  endfunction

  function automatic bit digitHidden();
`ifdef DISP_LZB_EN
    return (mDigit > 0) && ((mFrame >> (4 * mDigit)) == 32'h0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [7:0] expAn();
    if (mMode == SHOWING && !digitHidden()) return ~(8'(1) << mDigit);
    return 8'hFF;
  endfunction

  function automatic logic [6:0] expSeg();
    logic [3:0] nib;
    nib = 4'(mFrame >> (4 * mDigit));
    if (mMode == SHOWING && !digitHidden()) return hexTab[nib];
    return 7'h7F;
  endfunction

  function automatic logic expDp();
    return !(mMode == SHOWING && mDigit == 0 && mShown);
  endfunction

  task automatic checkAll();
    checkOutput("an", an, expAn());
    checkOutput("seg", seg, expSeg());
    checkOutput("dp", dp, expDp());
    checkOutput("page", pageOut, mShown);
    checkOutput("frame_done", frameDone, mDone);
    checkOutput("an_one_low", 32'($countones(~an) <= 1), 1);
  endtask

  task automatic stepCycle();
    @(posedge clk);
    modelEdge();
    #1;
    checkAll();
    if (frameDone === 1'b1) fdCount++;
    if (watchLit && an !== 8'hFF) begin
      firstLit = an;
      watchLit = 1'b0;
    end
    #1;
  endtask

  task automatic scanEdge();
    tickScan = 1'b1;
    repeat (6) stepCycle();
    tickScan = 1'b0;
    repeat (6) stepCycle();
  endtask

  // One cycle of free-running ticks with occasional mode, select and page-word changes.
  task automatic applyStimulus();
    logic [31:0] w;
    if (scanCnt == 0) begin
      tickScan = ~tickScan;
      scanCnt  = $urandom_range(3, 14);
    end else begin
      scanCnt--;
    end
    if (pageCnt == 0) begin
      tickPage = ~tickPage;
      pageCnt  = $urandom_range(15, 70);
    end else begin
      pageCnt--;
    end
    if ($urandom_range(0, 99) == 0) autoEn = ~autoEn;
    if ($urandom_range(0, 39) == 0) pageSel = ~pageSel;
    if ($urandom_range(0, 49) == 0) begin
      w = $urandom;
      page0 = w >> (4 * $urandom_range(0, 8));
    end
    if ($urandom_range(0, 49) == 0) begin
      w = $urandom;
      page1 = w >> (4 * $urandom_range(0, 8));
    end
    stepCycle();
  endtask

  initial begin
    modelReset();
    #1;
    rst = 1'b0;
    #1;
    checkOutput("reset_an", an, 8'hFF);
    checkOutput("reset_seg", seg, 7'h7F);
    checkOutput("reset_dp", dp, 1'b1);
    checkOutput("reset_page", pageOut, 1'b0);
    checkOutput("reset_frame_done", frameDone, 1'b0);
    repeat (3) stepCycle();

    page0 = 32'h76543210;
    page1 = 32'hFFFFFFFF;
    rst   = 1'b1;
    repeat (2) stepCycle();

    // Nine scans: one full frame plus the wrap back to digit 0.
    fdCount = 0;
    repeat (9) scanEdge();
    checkOutput("frame_done_count", fdCount, 1);

    // Automatic paging with a page tick in the middle of a frame.
    autoEn = 1'b1;
    repeat (2) scanEdge();
    tickPage = 1'b1;
    scanEdge();
    checkOutput("page_held_mid_frame", pageOut, 1'b0);
    repeat (5) scanEdge();
    checkOutput("page_after_wrap", pageOut, 1'b1);
    checkOutput("seg_after_wrap", seg, 7'h0E);
    checkOutput("dp_digit0_page1", dp, 1'b0);
    tickPage = 1'b0;

    // Asynchronous reset while digit 5 is lit.
    for (int i = 0; i < 20 && !(mMode == SHOWING && mDigit == 5); i++) scanEdge();
    checkOutput("drive_idx5", an, 8'hDF);
    rst = 1'b0;
    modelReset();
    #1;
    checkOutput("async_an", an, 8'hFF);
    checkOutput("async_seg", seg, 7'h7F);
    checkOutput("async_page", pageOut, 1'b0);
    #1;
    repeat (2) stepCycle();
    rst      = 1'b1;
    autoEn   = 1'b0;
    watchLit = 1'b1;
    firstLit = 8'hFF;
    repeat (3) scanEdge();
    checkOutput("first_lit_digit", firstLit, 8'hFE);

    // Leading zero pattern; digits 7..3 dark only when blanking is built in.
    page0   = 32'h00000A05;
    pageSel = 1'b0;
    repeat (10) scanEdge();

    repeat (2500) applyStimulus();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
